// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller command port between NUM_PORTS clients.
// Define SDRAM_ARB_TIMEOUT_EN to abort an ISSUE that sees no controller busy within TIMEOUT cycles.
module sdram_port_arbiter #(
   parameter int NUM_PORTS = 4,
   parameter int TIMEOUT   = 1024
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_PORTS-1:0]    port_req,
   input  logic [NUM_PORTS-1:0]    port_we,
   input  logic [24*NUM_PORTS-1:0] port_addr,
   input  logic [64*NUM_PORTS-1:0] port_wdata,
   input  logic [4*NUM_PORTS-1:0]  port_burst,
   output logic [NUM_PORTS-1:0]    port_ack,
   output logic [NUM_PORTS-1:0]    port_done,
   output logic [NUM_PORTS-1:0]    port_err,
   output logic [63:0]             port_rdata,
   output logic                    arb_busy,
   output logic                    rd_in,
   output logic                    wr_in,
   output logic [23:0]             rd_addr,
   output logic [23:0]             wr_addr,
   output logic [3:0]              rd_burst_length,
   output logic [3:0]              wr_burst_length,
   output logic [63:0]             wr_data,
   input  logic [63:0]             rd_data,
   input  logic                    reading,
   input  logic                    writing
);

   localparam int IW = $clog2(NUM_PORTS);

   if (NUM_PORTS < 2 || NUM_PORTS > 8 || TIMEOUT < 1) begin : g_bad_cfg
      $error("sdram_port_arbiter: NUM_PORTS must be 2..8, TIMEOUT >= 1");
   end

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_DONE,
      DONE
   } state_t;

   state_t st, st_n;

   logic [IW-1:0]        last, last_n;
   logic [IW-1:0]        grant, grant_n;
   logic [IW-1:0]        pick;
   logic                 found;
   logic                 we_q, we_n;
   logic                 busy_m;

   logic [NUM_PORTS-1:0] ack_n, done_n;
   logic [63:0]          rdata_n, wr_data_n;
   logic                 rd_in_n, wr_in_n, arb_busy_n;
   logic [23:0]          rd_addr_n, wr_addr_n;
   logic [3:0]           rd_bl_n, wr_bl_n;

   logic [23:0]          sel_addr;
   logic [63:0]          sel_wdata;
   logic [3:0]           sel_burst;

`ifdef SDRAM_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0]        cnt, cnt_n;
   logic [NUM_PORTS-1:0] err_n;
`endif

   function automatic logic [3:0] clamp_burst(input logic [3:0] b);
      if (b == 4'd0)
         return 4'd1;
      if (b > 4'd8)
         return 4'd8;
      return b;
   endfunction

   // First requester after the previous winner, wrapping around.
   always_comb begin
      logic [IW-1:0] idx;
      int            j;
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      j     = 0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         j   = (int'(last) + k) % NUM_PORTS;
         idx = IW'(j);
         if (!found && port_req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   assign sel_addr  = port_addr[24*int'(pick) +: 24];
   assign sel_wdata = port_wdata[64*int'(pick) +: 64];
   assign sel_burst = port_burst[4*int'(pick) +: 4];
   assign busy_m    = we_q ? writing : reading;

   always_comb begin
      st_n      = st;
      last_n    = last;
      grant_n   = grant;
      we_n      = we_q;
      ack_n     = '0;
      done_n    = '0;
      rdata_n   = port_rdata;
      rd_in_n   = rd_in;
      wr_in_n   = wr_in;
      rd_addr_n = rd_addr;
      wr_addr_n = wr_addr;
      rd_bl_n   = rd_burst_length;
      wr_bl_n   = wr_burst_length;
      wr_data_n = wr_data;
`ifdef SDRAM_ARB_TIMEOUT_EN
      err_n     = '0;
      cnt_n     = cnt;
`endif
      unique case (st)
         IDLE: begin
            if (found) begin
               st_n        = ISSUE;
               last_n      = pick;
               grant_n     = pick;
               we_n        = port_we[pick];
               ack_n[pick] = 1'b1;
`ifdef SDRAM_ARB_TIMEOUT_EN
               cnt_n       = '0;
`endif
               if (port_we[pick]) begin
                  wr_in_n   = 1'b1;
                  wr_addr_n = sel_addr;
                  wr_bl_n   = clamp_burst(sel_burst);
                  wr_data_n = sel_wdata;
                  rd_in_n   = 1'b0;
                  rd_addr_n = '0;
                  rd_bl_n   = '0;
               end else begin
                  rd_in_n   = 1'b1;
                  rd_addr_n = sel_addr;
                  rd_bl_n   = clamp_burst(sel_burst);
                  wr_in_n   = 1'b0;
                  wr_addr_n = '0;
                  wr_bl_n   = '0;
                  wr_data_n = '0;
               end
            end
         end
         ISSUE: begin
            if (busy_m) begin
               rd_in_n = 1'b0;
               wr_in_n = 1'b0;
               st_n    = WAIT_DONE;
            end
`ifdef SDRAM_ARB_TIMEOUT_EN
            // Abort path reuses DONE so the err pulse mirrors a done pulse.
            else if (cnt == CW'(TIMEOUT - 1)) begin
               rd_in_n      = 1'b0;
               wr_in_n      = 1'b0;
               err_n[grant] = 1'b1;
               st_n         = DONE;
            end else begin
               cnt_n = cnt + CW'(1);
            end
`endif
         end
         WAIT_DONE: begin
            if (!busy_m) begin
               if (!we_q)
                  rdata_n = rd_data;
               done_n[grant] = 1'b1;
               st_n          = DONE;
            end
         end
         DONE: begin
            st_n = IDLE;
         end
         default: begin
            st_n = IDLE;
         end
      endcase
      arb_busy_n = (st_n != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st              <= IDLE;
         last            <= IW'(NUM_PORTS - 1);
         grant           <= '0;
         we_q            <= 1'b0;
         port_ack        <= '0;
         port_done       <= '0;
         port_rdata      <= '0;
         arb_busy        <= 1'b0;
         rd_in           <= 1'b0;
         wr_in           <= 1'b0;
         rd_addr         <= '0;
         wr_addr         <= '0;
         rd_burst_length <= '0;
         wr_burst_length <= '0;
         wr_data         <= '0;
      end else begin
         st              <= st_n;
         last            <= last_n;
         grant           <= grant_n;
         we_q            <= we_n;
         port_ack        <= ack_n;
         port_done       <= done_n;
         port_rdata      <= rdata_n;
         arb_busy        <= arb_busy_n;
         rd_in           <= rd_in_n;
         wr_in           <= wr_in_n;
         rd_addr         <= rd_addr_n;
         wr_addr         <= wr_addr_n;
         rd_burst_length <= rd_bl_n;
         wr_burst_length <= wr_bl_n;
         wr_data         <= wr_data_n;
      end
   end

`ifdef SDRAM_ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         port_err <= '0;
      end else begin
         cnt      <= cnt_n;
         port_err <= err_n;
      end
   end
`else
   assign port_err = '0;
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a small controller busy model.
// Timeout case runs only when SDRAM_ARB_TIMEOUT_EN is defined.
module tb_sdram_port_arbiter;

   localparam int NP = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NP-1:0]    port_req;
   logic [NP-1:0]    port_we;
   logic [24*NP-1:0] port_addr;
   logic [64*NP-1:0] port_wdata;
   logic [4*NP-1:0]  port_burst;
   logic [NP-1:0]    port_ack;
   logic [NP-1:0]    port_done;
   logic [NP-1:0]    port_err;
   logic [63:0]      port_rdata;
   logic             arb_busy;
   logic             rd_in, wr_in;
   logic [23:0]      rd_addr, wr_addr;
   logic [3:0]       rd_burst_length, wr_burst_length;
   logic [63:0]      wr_data;
   logic [63:0]      rd_data;
   logic             reading, writing;

   always #5 clk = ~clk;

   sdram_port_arbiter #(
      .NUM_PORTS(NP),
      .TIMEOUT(16)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .port_req(port_req),
      .port_we(port_we),
      .port_addr(port_addr),
      .port_wdata(port_wdata),
      .port_burst(port_burst),
      .port_ack(port_ack),
      .port_done(port_done),
      .port_err(port_err),
      .port_rdata(port_rdata),
      .arb_busy(arb_busy),
      .rd_in(rd_in),
      .wr_in(wr_in),
      .rd_addr(rd_addr),
      .wr_addr(wr_addr),
      .rd_burst_length(rd_burst_length),
      .wr_burst_length(wr_burst_length),
      .wr_data(wr_data),
      .rd_data(rd_data),
      .reading(reading),
      .writing(writing)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Controller model: busy rises m_delay negedges after a request, lasts m_len.
   int m_delay = 0;
   int m_len   = 1;
   bit m_off   = 1'b0;

   initial begin
      reading = 1'b0;
      writing = 1'b0;
      forever begin
         @(negedge clk);
         if (!m_off && rst_n && (rd_in || wr_in)) begin
            bit w;
            w = wr_in;
            repeat (m_delay) @(negedge clk);
            if (w)
               writing = 1'b1;
            else
               reading = 1'b1;
            repeat (m_len) @(negedge clk);
            writing = 1'b0;
            reading = 1'b0;
         end
      end
   end

   int            r_rdin, r_wrin, r_done;
   logic [NP-1:0] r_done_v;
   logic [63:0]   r_rdata;
   bit            r_fell;

   // Call on the ack cycle; runs until the arbiter returns to idle.
   task automatic wait_op(input int limit);
      bit prev_rd, prev_wr;
      r_rdin   = 0;
      r_wrin   = 0;
      r_done   = 0;
      r_done_v = '0;
      r_rdata  = '0;
      r_fell   = 1'b0;
      prev_rd  = reading;
      prev_wr  = writing;
      for (int i = 0; i < limit; i++) begin
         if (rd_in) r_rdin++;
         if (wr_in) r_wrin++;
         if (port_done != '0) begin
            r_done++;
            r_done_v = port_done;
            r_rdata  = port_rdata;
            r_fell   = (!reading && prev_rd) || (!writing && prev_wr);
         end
         if (!arb_busy)
            return;
         prev_rd = reading;
         prev_wr = writing;
         tick();
      end
      check("op_bound", 64'(arb_busy), 64'd0);
   endtask

   logic [23:0] rr_addr [NP];
   int          ack_idx [5];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n_ack;
      int overlap;
      int nd;
      bit pw;

      port_req   = '0;
      port_we    = '0;
      port_addr  = '0;
      port_wdata = '0;
      port_burst = '0;
      rd_data    = 64'hDEADBEEF_CAFEF00D;

      // Reset state
      rst_n = 1'b0;
      repeat (3) tick();
      check("rst_busy", 64'(arb_busy), 64'd0);
      check("rst_rdin", 64'(rd_in), 64'd0);
      check("rst_wrin", 64'(wr_in), 64'd0);
      check("rst_ack", 64'(port_ack), 64'd0);
      check("rst_rdata", port_rdata, 64'd0);
      rst_n = 1'b1;
      tick();

      // Single read on port 1
      m_delay = 2;
      m_len   = 3;
      port_we[1]       = 1'b0;
      port_addr[47:24] = 24'h000123;
      port_burst[7:4]  = 4'd4;
      port_req[1]      = 1'b1;
      tick();
      check("rd1_ack", 64'(port_ack), 64'h2);
      check("rd1_rdin", 64'(rd_in), 64'd1);
      check("rd1_wrin", 64'(wr_in), 64'd0);
      check("rd1_addr", 64'(rd_addr), 64'h000123);
      check("rd1_len", 64'(rd_burst_length), 64'd4);
      check("rd1_waddr", 64'(wr_addr), 64'd0);
      check("rd1_busy", 64'(arb_busy), 64'd1);
      port_req = '0;
      wait_op(100);
      check("rd1_rdin_cyc", 64'(r_rdin), 64'd3);
      check("rd1_ndone", 64'(r_done), 64'd1);
      check("rd1_done", 64'(r_done_v), 64'h2);
      check("rd1_data", r_rdata, 64'hDEADBEEF_CAFEF00D);
      check("rd1_fell", 64'(r_fell), 64'd1);
      check("rd1_err", 64'(port_err), 64'd0);

      // Round-robin, all ports writing
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      m_delay = 1;
      m_len   = 2;
      for (int i = 0; i < NP; i++) begin
         rr_addr[i]            = 24'h010000 * (i + 1);
         port_we[i]            = 1'b1;
         port_addr[24*i +: 24] = rr_addr[i];
         port_wdata[64*i +: 64] = 64'h1000 + 64'(i);
         port_burst[4*i +: 4]  = 4'd8;
      end
      port_req = '1;
      n_ack    = 0;
      overlap  = 0;
      pw       = 1'b0;
      for (int t = 0; t < 300 && n_ack < 5; t++) begin
         tick();
         if (wr_in && !pw && writing)
            overlap++;
         pw = wr_in;
         if (port_ack != '0) begin
            int idx;
            idx = 0;
            for (int p = 0; p < NP; p++)
               if (port_ack[p]) idx = p;
            ack_idx[n_ack] = idx;
            check("rr_addr", 64'(wr_addr), 64'(rr_addr[idx]));
            n_ack++;
         end
      end
      port_req = '0;
      check("rr_nack", 64'(n_ack), 64'd5);
      for (int k = 0; k < 5; k++)
         check("rr_order", 64'(ack_idx[k]), 64'(k % NP));
      check("rr_overlap", 64'(overlap), 64'd0);
      wait_op(100);

      // Burst clamp: 0 -> 1 on write, 12 -> 8 on read
      port_we    = 4'b0001;
      port_addr  = '0;
      port_burst = '0;
      port_addr[23:0] = 24'hABCDEF;
      port_req   = 4'b0001;
      tick();
      check("clamp0_wlen", 64'(wr_burst_length), 64'd1);
      check("clamp0_rlen", 64'(rd_burst_length), 64'd0);
      check("clamp0_waddr", 64'(wr_addr), 64'hABCDEF);
      check("clamp0_raddr", 64'(rd_addr), 64'd0);
      port_req = '0;
      wait_op(100);
      port_we          = '0;
      port_addr[47:24] = 24'h00BEEF;
      port_burst[7:4]  = 4'd12;
      port_req         = 4'b0010;
      tick();
      check("clamp12_rlen", 64'(rd_burst_length), 64'd8);
      check("clamp12_wlen", 64'(wr_burst_length), 64'd0);
      check("clamp12_waddr", 64'(wr_addr), 64'd0);
      port_req = '0;
      wait_op(100);
      check("clamp12_done", 64'(r_done_v), 64'h2);

      // Delayed busy on port 2
      m_delay = 50;
      m_len   = 10;
      rd_data = 64'h01234567_89ABCDEF;
      port_addr[71:48] = 24'h222222;
      port_burst[11:8] = 4'd2;
      port_req         = 4'b0100;
      tick();
      check("dly_ack", 64'(port_ack), 64'h4);
      port_req = '0;
      wait_op(200);
      check("dly_rdin_cyc", 64'(r_rdin), 64'd51);
      check("dly_ndone", 64'(r_done), 64'd1);
      check("dly_done", 64'(r_done_v), 64'h4);
      check("dly_data", r_rdata, 64'h01234567_89ABCDEF);

      // Reset during WAIT_DONE of a port 1 read
      m_delay  = 1;
      m_len    = 20;
      port_req = 4'b0010;
      tick();
      port_req = '0;
      repeat (5) tick();
      check("rmid_pre_rdin", 64'(rd_in), 64'd0);
      check("rmid_pre_busy", 64'(arb_busy), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rmid_busy", 64'(arb_busy), 64'd0);
      check("rmid_raddr", 64'(rd_addr), 64'd0);
      check("rmid_rlen", 64'(rd_burst_length), 64'd0);
      check("rmid_rdata", port_rdata, 64'd0);
      tick();
      rst_n = 1'b1;
      nd = 0;
      repeat (25) begin
         tick();
         if (port_done != '0) nd++;
      end
      check("rmid_nodone", 64'(nd), 64'd0);
      m_delay  = 0;
      m_len    = 2;
      port_req = 4'b0101;
      tick();
      check("rmid_next", 64'(port_ack), 64'h1);
      port_req = '0;
      wait_op(100);

`ifdef SDRAM_ARB_TIMEOUT_EN
      // Busy never rises: err after 16 ISSUE cycles
      begin
         int k;
         m_off    = 1'b1;
         port_we  = '0;
         port_req = 4'b0001;
         tick();
         port_req = '0;
         k = 0;
         while (port_err == '0 && k < 40) begin
            tick();
            k++;
         end
         check("to_cycle", 64'(k), 64'd16);
         check("to_err", 64'(port_err), 64'h1);
         check("to_rdin", 64'(rd_in), 64'd0);
         check("to_done", 64'(port_done), 64'd0);
         tick();
         check("to_busy", 64'(arb_busy), 64'd0);
         m_off = 1'b0;
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
